// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths.
//   state_t      : receiver FSM encoding (IDLE, START, DATA, STOP)
//   OVS          : oversampling ticks per bit time
//   MID_START    : tick index that lands in the middle of the start bit
//   DEF_*        : default frame geometry (8 data bits, 1 stop bit)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } state_t;

  localparam int OVS         = 16;
  localparam int MID_START   = 7;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_NB_TICK = 5;
  localparam int DEF_NB_BIT  = 3;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer_if
// Bundles the receiver's data-path signals.
//   i_s_tick       : 16x baud strobe from the shared baud generator
//   i_rx           : raw asynchronous serial line, idle high
//   o_dout         : last good received byte
//   o_rx_done_tick : one-cycle pulse, o_dout is new and valid
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_busy         : receiver is inside a frame
// master drives the line and tick (source / testbench side),
// slave is the receiver itself.
// ---------------------------------------------------------------------------
interface uart_rx_deserializer_if #(
  parameter int DBIT = uart_pkg::DEF_DBIT
);

  logic            i_s_tick;
  logic            i_rx;
  logic [DBIT-1:0] o_dout;
  logic            o_rx_done_tick;
  logic            o_frame_err;
  logic            o_busy;

  modport master (
    output i_s_tick,
    output i_rx,
    input  o_dout,
    input  o_rx_done_tick,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_s_tick,
    input  i_rx,
    output o_dout,
    output o_rx_done_tick,
    output o_frame_err,
    output o_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous input.
//   clock   : destination clock
//   i_reset : synchronous, active-low reset; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronised output, two clocks behind d
// RST_VAL should match the input's idle level so that releasing reset
// does not present a false edge downstream.
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic i_reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
// UART receiver with 16x oversampling. Recovers DBIT-data-bit frames
// (LSB first) with SB_TICK ticks of stop bit, and emits each good byte
// with a one-cycle done strobe that writes the downstream RX FIFO.
// A stop bit sampled low raises a one-cycle frame-error strobe instead
// and the byte is dropped (o_dout keeps its previous value).
//   clock   : system clock, rising edge
//   i_reset : synchronous, active-low reset
//   rx_bus  : slave side of uart_rx_deserializer_if (tick, line, outputs)
// Constraints: 2**NB_TICK > SB_TICK, 2**NB_BIT >= DBIT.
// ---------------------------------------------------------------------------
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int NB_TICK = DEF_NB_TICK,
  parameter int NB_BIT  = DEF_NB_BIT
) (
  input  logic                  clock,
  input  logic                  i_reset,
  uart_rx_deserializer_if.slave rx_bus
);

  localparam logic [NB_TICK-1:0] TICK_MID  = NB_TICK'(MID_START);
  localparam logic [NB_TICK-1:0] TICK_BIT  = NB_TICK'(OVS - 1);
  localparam logic [NB_TICK-1:0] TICK_STOP = NB_TICK'(SB_TICK - 1);
  localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(DBIT - 1);
  localparam logic [NB_TICK-1:0] TICK_ONE  = NB_TICK'(1);
  localparam logic [NB_BIT-1:0]  BIT_ONE   = NB_BIT'(1);

  logic rx_s;

  state_t            state_reg, state_next;
  logic [NB_TICK-1:0] tick_reg, tick_next;
  logic [NB_BIT-1:0]  bit_reg, bit_next;
  logic [DBIT-1:0]    shift_reg, shift_next;
  logic [DBIT-1:0]    dout_reg, dout_next;
  logic               done_reg, done_next;
  logic               ferr_reg, ferr_next;
  logic               busy_reg;

  // Line idles high, so the synchroniser resets to 1 to avoid a fake
  // start bit right after reset release.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clock   (clock),
    .i_reset (i_reset),
    .d       (rx_bus.i_rx),
    .q       (rx_s)
  );

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
      // Registered from the next state so busy tracks state_reg exactly.
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    ferr_next  = 1'b0;

    case (state_reg)
      // Start edge is taken on any clock, not only on a tick, so a frame
      // that follows immediately after a stop bit is never missed.
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          tick_next  = '0;
        end
      end

      // Re-check the line in the middle of the start bit; a high level
      // there means the falling edge was a glitch.
      ST_START: begin
        if (rx_bus.i_s_tick) begin
          if (tick_reg == TICK_MID) begin
            if (!rx_s) begin
              state_next = ST_DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
      end

      // Sampling is aligned to the middle of each bit, a full bit time
      // after the mid-start point. Bits arrive LSB first, so shift right.
      ST_DATA: begin
        if (rx_bus.i_s_tick) begin
          if (tick_reg == TICK_BIT) begin
            tick_next  = '0;
            shift_next = {rx_s, shift_reg[DBIT-1:1]};
            if (bit_reg == BIT_LAST) begin
              state_next = ST_STOP;
            end else begin
              bit_next = bit_reg + BIT_ONE;
            end
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
      end

      ST_STOP: begin
        if (rx_bus.i_s_tick) begin
          if (tick_reg == TICK_STOP) begin
            state_next = ST_IDLE;
            if (rx_s) begin
              dout_next = shift_reg;
              done_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            tick_next = tick_reg + TICK_ONE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_bus.o_dout         = dout_reg;
  assign rx_bus.o_rx_done_tick = done_reg;
  assign rx_bus.o_frame_err    = ferr_reg;
  assign rx_bus.o_busy         = busy_reg;

endmodule
